// File: rtl/ysyx_22050612_ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   ifu_state_e      : FSM state encoding (3 bits)
//   NOP_INST         : instruction presented when no valid word exists (addi x0,x0,0)
//   DEFAULT_RESET_PC : default PC after reset
//   TIMER_W          : width of the response timeout counter
//   FAULT_CAUSE_W    : reserved width for a future fault-cause field
package ysyx_22050612_ifu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_WAIT_RSP = 3'd1,
        ST_DELIVER  = 3'd2,
        ST_WAIT_NPC = 3'd3,
        ST_HALTED   = 3'd4
    } ifu_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;
    localparam int unsigned TIMER_W          = 16;
    localparam int unsigned FAULT_CAUSE_W    = 2;

endpackage

// File: rtl/ysyx_22050612_ifu_timer.sv
// Response timeout counter for the fetch unit.
// Counts enabled cycles from a clear and saturates at the limit. 'expired'
// is high during the TIMEOUT-th enabled cycle after a clear, so the owner
// can leave its wait state on exactly that clock edge.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to zero (wins over en)
//   en       : count this cycle
//   expired  : current enabled cycle is the TIMEOUT-th since clear
module ysyx_22050612_ifu_timer
    import ysyx_22050612_ifu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned       LIMIT_I = TIMEOUT - 1;
    localparam logic [TIMER_W-1:0] LIMIT  = LIMIT_I[TIMER_W-1:0];

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The count holds the number of cycles already spent, so the cycle that
    // completes TIMEOUT waiting cycles is the one where cnt == TIMEOUT-1.
    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit.
// Holds the PC, issues one fetch at a time to instruction memory, hands the
// word to execute over valid/ready, then waits for execute to report the
// next PC before fetching again. Misaligned PCs, bus errors and response
// timeouts are delivered as faulted instructions (inst = nop).
//   clk, rst                         : clock, asynchronous active-high reset
//   imem_req_valid/ready/addr        : fetch request channel
//   imem_rsp_valid/data/err          : fetch response (single-cycle pulse)
//   inst_valid/ready, inst, inst_pc,
//   inst_fault                       : instruction handed to execute
//   dnpc_valid, dnpc                 : next PC returned by execute
//   halt                             : stop fetching, sticky until reset
//   fetch_cnt                        : completed instruction handshakes
module ysyx_22050612_ifu
    import ysyx_22050612_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_fault,
    input  logic        dnpc_valid,
    input  logic [63:0] dnpc,
    input  logic        halt,
    output logic [63:0] fetch_cnt
);

    ifu_state_e  state, state_n;
    logic [63:0] pc, pc_n;
    logic [31:0] inst_n;
    logic [63:0] inst_pc_n;
    logic        inst_fault_n;
    logic [63:0] fetch_cnt_n;
    logic        halted, halted_n;
    logic        halt_any;
    logic        pc_aligned;
    logic        tmr_clr, tmr_en, tmr_expired;

    ysyx_22050612_ifu_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    // A halt seen in WAIT_RSP must survive until the outstanding response
    // (or timeout) retires, so it is remembered in 'halted'.
    assign halt_any   = halt || halted;
    assign pc_aligned = (pc[1:0] == 2'b00);

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_n       = inst;
        inst_pc_n    = inst_pc;
        inst_fault_n = inst_fault;
        fetch_cnt_n  = fetch_cnt;
        halted_n     = halted || halt;
        tmr_clr      = 1'b0;
        tmr_en       = 1'b0;

        unique case (state)
            ST_FETCH: begin
                if (!pc_aligned) begin
                    // No bus request for a misaligned PC; deliver a fault.
                    if (halt_any) begin
                        state_n = ST_HALTED;
                    end else begin
                        state_n      = ST_DELIVER;
                        inst_n       = NOP_INST;
                        inst_pc_n    = pc;
                        inst_fault_n = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    // An accepted request always retires through WAIT_RSP,
                    // even if halt arrives in the same cycle.
                    state_n = ST_WAIT_RSP;
                    tmr_clr = 1'b1;
                end else if (halt_any) begin
                    state_n = ST_HALTED;
                end
            end

            ST_WAIT_RSP: begin
                tmr_en = 1'b1;
                if (imem_rsp_valid || tmr_expired) begin
                    if (halt_any) begin
                        state_n = ST_HALTED;
                    end else begin
                        state_n   = ST_DELIVER;
                        inst_pc_n = pc;
                        // A response on the limit cycle beats the timeout.
                        if (imem_rsp_valid) begin
                            inst_n       = imem_rsp_data;
                            inst_fault_n = imem_rsp_err;
                        end else begin
                            inst_n       = NOP_INST;
                            inst_fault_n = 1'b1;
                        end
                    end
                end
            end

            ST_DELIVER: begin
                if (inst_ready) begin
                    fetch_cnt_n = fetch_cnt + 64'd1;
                    state_n     = halt_any ? ST_HALTED : ST_WAIT_NPC;
                end else if (halt_any) begin
                    state_n = ST_HALTED;
                end
            end

            ST_WAIT_NPC: begin
                if (halt_any) begin
                    state_n = ST_HALTED;
                end else if (dnpc_valid) begin
                    pc_n    = dnpc;
                    state_n = ST_FETCH;
                end
            end

            ST_HALTED: begin
                state_n = ST_HALTED;
            end

            default: begin
                state_n = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            inst       <= NOP_INST;
            inst_pc    <= RESET_PC;
            inst_fault <= 1'b0;
            fetch_cnt  <= 64'd0;
            halted     <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
            inst_fault <= inst_fault_n;
            fetch_cnt  <= fetch_cnt_n;
            halted     <= halted_n;
        end
    end

    assign imem_req_valid = (state == ST_FETCH) && pc_aligned;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == ST_DELIVER);

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Scoreboard bench for the instruction fetch unit.
module tb_ysyx_22050612_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;
    logic        dnpc_valid;
    logic [63:0] dnpc;
    logic        halt;
    logic [63:0] fetch_cnt;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        fault;
    } exp_inst_t;

    logic [63:0] req_q[$];
    exp_inst_t   inst_q[$];
    logic [63:0] exp_addr;
    exp_inst_t   exp_i;

    int tests = 0;
    int fails = 0;

    ysyx_22050612_ifu #(
        .RESET_PC (64'h8000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault),
        .dnpc_valid     (dnpc_valid),
        .dnpc           (dnpc),
        .halt           (halt),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every request and instruction handshake against the
    // expectations queued by the stimulus.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_valid && imem_req_ready) begin
                if (req_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL req_unexpected: got addr %h expected no request", imem_req_addr);
                end else begin
                    exp_addr = req_q.pop_front();
                    chk("req_addr", imem_req_addr, exp_addr);
                end
            end
            if (inst_valid && inst_ready) begin
                if (inst_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL inst_unexpected: got inst %h pc %h expected no instruction", inst, inst_pc);
                end else begin
                    exp_i = inst_q.pop_front();
                    chk("hs_inst", 64'(inst), 64'(exp_i.inst));
                    chk("hs_pc", inst_pc, exp_i.pc);
                    chk("hs_fault", 64'(inst_fault), 64'(exp_i.fault));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        dnpc_valid     = 1'b0;
        dnpc           = 64'h0;
        halt           = 1'b0;

        tick();
        tick();
        chk("rst_inst", 64'(inst), 64'h13);
        chk("rst_inst_pc", inst_pc, 64'h8000_0000);
        chk("rst_fault", 64'(inst_fault), 64'h0);
        chk("rst_fetch_cnt", fetch_cnt, 64'h0);
        chk("rst_inst_valid", 64'(inst_valid), 64'h0);
        rst = 1'b0;
        #1;
        chk("rel_req_valid", 64'(imem_req_valid), 64'h1);
        chk("rel_req_addr", imem_req_addr, 64'h8000_0000);

        // Basic fetch with a one-cycle response
        req_q.push_back(64'h8000_0000);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", 64'(imem_req_valid), 64'h0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        tick();
        imem_rsp_valid = 1'b0;
        chk("t1_inst_valid", 64'(inst_valid), 64'h1);
        chk("t1_inst", 64'(inst), 64'h0010_0093);
        inst_q.push_back('{32'h0010_0093, 64'h8000_0000, 1'b0});
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("t1_fetch_cnt", fetch_cnt, 64'd1);
        chk("t1_npc_req_valid", 64'(imem_req_valid), 64'h0);
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0004;
        tick();
        dnpc_valid = 1'b0;
        chk("t1_next_req_valid", 64'(imem_req_valid), 64'h1);
        chk("t1_next_addr", imem_req_addr, 64'h8000_0004);

        // Memory back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req_valid", 64'(imem_req_valid), 64'h1);
            chk("stall_addr", imem_req_addr, 64'h8000_0004);
        end
        req_q.push_back(64'h8000_0004);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("stall_accepted", 64'(imem_req_valid), 64'h0);

        // Bus error response, then a stray response during DELIVER
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        imem_rsp_err   = 1'b1;
        tick();
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'h1234_5678;
        chk("err_fault", 64'(inst_fault), 64'h1);
        chk("err_inst", 64'(inst), 64'hDEAD_BEEF);
        tick();
        imem_rsp_valid = 1'b0;
        chk("stray_rsp_inst", 64'(inst), 64'hDEAD_BEEF);
        chk("stray_rsp_valid", 64'(inst_valid), 64'h1);
        inst_q.push_back('{32'hDEAD_BEEF, 64'h8000_0004, 1'b1});
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("err_fetch_cnt", fetch_cnt, 64'd2);

        // Misaligned next PC
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0006;
        tick();
        dnpc_valid = 1'b0;
        chk("mis_no_req", 64'(imem_req_valid), 64'h0);
        tick();
        chk("mis_valid", 64'(inst_valid), 64'h1);
        chk("mis_fault", 64'(inst_fault), 64'h1);
        chk("mis_inst", 64'(inst), 64'h13);
        chk("mis_pc", inst_pc, 64'h8000_0006);
        inst_q.push_back('{32'h0000_0013, 64'h8000_0006, 1'b1});
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_0008;
        tick();

        // Stray dnpc while in FETCH
        dnpc       = 64'h9000_0000;
        tick();
        dnpc_valid = 1'b0;
        chk("stray_dnpc_addr", imem_req_addr, 64'h8000_0008);
        chk("stray_dnpc_valid", 64'(imem_req_valid), 64'h1);

        // Timeout: fault appears exactly 4 cycles after acceptance
        req_q.push_back(64'h8000_0008);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("to_early_valid", 64'(inst_valid), 64'h0);
        end
        tick();
        chk("to_valid", 64'(inst_valid), 64'h1);
        chk("to_fault", 64'(inst_fault), 64'h1);
        chk("to_inst", 64'(inst), 64'h13);
        chk("to_pc", inst_pc, 64'h8000_0008);
        inst_q.push_back('{32'h0000_0013, 64'h8000_0008, 1'b1});
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("to_fetch_cnt", fetch_cnt, 64'd4);
        dnpc_valid = 1'b1;
        dnpc       = 64'h8000_000C;
        tick();
        dnpc_valid = 1'b0;

        // Reset in the middle of WAIT_RSP
        req_q.push_back(64'h8000_000C);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("arst_fetch_cnt", fetch_cnt, 64'h0);
        chk("arst_req_valid", 64'(imem_req_valid), 64'h1);
        chk("arst_addr", imem_req_addr, 64'h8000_0000);
        chk("arst_inst_pc", inst_pc, 64'h8000_0000);
        chk("arst_inst", 64'(inst), 64'h13);
        tick();
        rst = 1'b0;
        // Stale response just after reset release
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        tick();
        imem_rsp_valid = 1'b0;
        chk("stale_inst_valid", 64'(inst_valid), 64'h0);
        chk("stale_inst", 64'(inst), 64'h13);
        chk("stale_req_valid", 64'(imem_req_valid), 64'h1);

        // Halt raised while waiting for a response
        req_q.push_back(64'h8000_0000);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        halt = 1'b1;
        tick();
        tick();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h1111_1111;
        tick();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_inst_valid", 64'(inst_valid), 64'h0);
            chk("halt_req_valid", 64'(imem_req_valid), 64'h0);
        end
        chk("halt_inst_dropped", 64'(inst), 64'h13);

        // Reset leaves HALTED and fetching restarts
        halt = 1'b0;
        rst  = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("restart_req_valid", 64'(imem_req_valid), 64'h1);
        chk("restart_addr", imem_req_addr, 64'h8000_0000);
        req_q.push_back(64'h8000_0000);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0020_0113;
        tick();
        imem_rsp_valid = 1'b0;
        inst_q.push_back('{32'h0020_0113, 64'h8000_0000, 1'b0});
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("restart_fetch_cnt", fetch_cnt, 64'd1);

        tick();
        chk("req_q_drained", 64'(req_q.size()), 64'h0);
        chk("inst_q_drained", 64'(inst_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
